// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : instruction fetch FIFO between instruction memory and decode
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     a_rstn,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [XLEN-1:0]          i_instr,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [XLEN-1:0]          o_pc,
  output logic [XLEN-1:0]          o_instr,
  output logic                     o_misaligned,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int              AW     = $clog2(DEPTH);
  localparam logic [AW:0]     C_FULL = (AW+1)'(DEPTH);
  localparam logic [XLEN-1:0] C_NOP  = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];
  logic            r_mis_mem   [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_ready = (r_count != C_FULL);
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  // Flush wins over both push and pop; full queue never passes a push through.
  assign w_push = i_valid && o_ready && !i_flush;
  assign w_pop  = o_valid && i_ready && !i_flush;

  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale data is hidden by the o_valid mask below.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]    <= i_pc;
      r_instr_mem[r_wptr] <= i_instr;
      r_mis_mem[r_wptr]   <= (i_pc[1:0] != 2'b00);
    end
  end

  assign o_pc         = o_valid ? r_pc_mem[r_rptr]    : '0;
  assign o_instr      = o_valid ? r_instr_mem[r_rptr] : C_NOP;
  assign o_misaligned = o_valid ? r_mis_mem[r_rptr]   : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : directed self-checking bench for fetch_queue
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk;
  logic            a_rstn;
  logic            i_flush;
  logic            i_valid;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_instr;
  logic            o_ready;
  logic            o_valid;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_instr;
  logic            o_misaligned;
  logic            i_ready;
  logic [2:0]      o_count;

  int n_checks;
  int n_errors;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
    .clk          (clk),
    .a_rstn       (a_rstn),
    .i_flush      (i_flush),
    .i_valid      (i_valid),
    .i_pc         (i_pc),
    .i_instr      (i_instr),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_pc         (o_pc),
    .o_instr      (o_instr),
    .o_misaligned (o_misaligned),
    .i_ready      (i_ready),
    .o_count      (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
    i_valid = 1'b1;
    i_pc    = pc;
    i_instr = instr;
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    a_rstn   = 1'b0;
    i_flush  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_pc     = '0;
    i_instr  = '0;

    #2;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_pc",    64'(o_pc),    64'd0);
    check("rst_instr", 64'(o_instr), 64'h13);
    check("rst_mis",   64'(o_misaligned), 64'd0);
    #11 a_rstn = 1'b1;
    step();

    // Fill to full with decode stalled.
    for (int k = 0; k < 4; k++) begin
      if (k == 0) check("no_bypass_valid", 64'(o_valid), 64'd0);
      push(XLEN'(4 * k), XLEN'(32'hA0 + k));
    end
    check("full_count", 64'(o_count), 64'd4);
    check("full_ready", 64'(o_ready), 64'd0);
    check("full_pc",    64'(o_pc),    64'h0);
    check("full_instr", 64'(o_instr), 64'hA0);

    push(32'h100, 32'hDEAD);
    check("push_full_count", 64'(o_count), 64'd4);
    check("push_full_pc",    64'(o_pc),    64'h0);

    // Drain in order.
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_pc%0d", k),    64'(o_pc),    64'(4 * k));
      check($sformatf("drain_instr%0d", k), 64'(o_instr), 64'(32'hA0 + k));
      step();
    end
    check("empty_valid", 64'(o_valid), 64'd0);
    check("empty_instr", 64'(o_instr), 64'h13);
    check("empty_pc",    64'(o_pc),    64'd0);
    step();
    check("pop_empty_count", 64'(o_count), 64'd0);

    // Streaming at occupancy 2 across pointer wrap.
    i_ready = 1'b0;
    push(32'h10, 32'hB0);
    push(32'h14, 32'hB1);
    i_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      check($sformatf("stream_count%0d", j), 64'(o_count), 64'd2);
      check($sformatf("stream_pc%0d", j),    64'(o_pc),    64'(32'h10 + 4 * j));
      i_valid = 1'b1;
      i_pc    = 32'h18 + 4 * j;
      i_instr = 32'hB2 + j;
      step();
    end
    i_valid = 1'b0;
    check("stream_end_pc",    64'(o_pc),    64'h38);
    check("stream_end_instr", 64'(o_instr), 64'hB0 + 64'd10);

    // Flush at count 3 with push and pop also requested.
    i_ready = 1'b0;
    push(32'h40, 32'hC0);
    check("preflush_count", 64'(o_count), 64'd3);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_pc    = 32'h44;
    i_instr = 32'hC1;
    #1;
    check("flushcyc_valid", 64'(o_valid), 64'd1);
    check("flushcyc_ready", 64'(o_ready), 64'd1);
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("flush_count", 64'(o_count), 64'd0);
    check("flush_valid", 64'(o_valid), 64'd0);
    check("flush_instr", 64'(o_instr), 64'h13);

    // Misaligned PC flag.
    push(32'h6, 32'hBEEF);
    check("mis_flag", 64'(o_misaligned), 64'd1);
    check("mis_pc",   64'(o_pc),         64'h6);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    push(32'h8, 32'hCAFE);
    check("aligned_flag",  64'(o_misaligned), 64'd0);
    check("aligned_instr", 64'(o_instr),      64'hCAFE);

    // Asynchronous reset mid-operation.
    push(32'hC, 32'hD1);
    push(32'h10, 32'hD2);
    check("prerst_count", 64'(o_count), 64'd3);
    #2 a_rstn = 1'b0;
    #1;
    check("async_valid", 64'(o_valid), 64'd0);
    check("async_count", 64'(o_count), 64'd0);
    check("async_ready", 64'(o_ready), 64'd1);
    #3 a_rstn = 1'b1;
    push(32'h50, 32'hE0);
    check("post_rst_count", 64'(o_count), 64'd1);
    check("post_rst_pc",    64'(o_pc),    64'h50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
